imm_encoder: RTL and testbench
==============================

IMM_ENCODER -- requirements
Module: imm_encoder

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning output buffer entries (legal values 2 only; other values are out of scope).
REQ-002 SHALL have port clk  input  1  rising-edge clock, the only clock of the block.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port in_valid  input  1  request present.
REQ-005 SHALL have port in_ready  output  1  request accepted this cycle when high with in_valid.
REQ-006 SHALL have port in_imm  input  32  full 32-bit immediate/offset value to pack.
REQ-007 SHALL have port in_src  input  2  target format (00 7-bit unsigned, 01 11-bit unsigned, 10 branch word offset, 11 illegal).
REQ-008 SHALL have port out_valid  output  1  result present at buffer head.
REQ-009 SHALL have port out_ready  input  1  consumer takes head when high with out_valid.
REQ-010 SHALL have port out_field  output  21  packed instruction immediate field Instr[20:0].
REQ-011 SHALL have port out_fit  output  1  1 = in_imm representable exactly in in_src format.
REQ-012 SHALL have port err_count  output  16  count of accepted requests with out_fit = 0, saturating.

Function
REQ-013 SHALL accept a request on each clk edge where in_valid && in_ready; never otherwise.
REQ-014 SHALL, for src 00, set fit = (in_imm[31:7] == 0), field = {14'b0, in_imm[6:0]}.
REQ-015 SHALL, for src 01, set fit = (in_imm[31:11] == 0), field = {10'b0, in_imm[10:0]}.
REQ-016 SHALL, for src 10, set fit = (in_imm[1:0] == 0) && (in_imm[31:22] all zeros or all ones), field = in_imm[22:2].
REQ-017 SHALL, for src 11, set fit = 0, field = 21'b0.
REQ-018 SHALL force field = 21'b0 whenever fit = 0, for every src.
REQ-019 SHALL guarantee for fit = 1: sign/zero-extending field per src (src 10: {9{field[20]}, field, 2'b00}) reproduces in_imm bit-exactly.
REQ-020 SHALL write each accepted result into a 2-entry FIFO; result visible on out_* the cycle after acceptance at earliest (latency 1).
REQ-021 SHALL hold occupancy count 0..2; push on accept, pop on out_valid && out_ready; simultaneous push+pop keeps count unchanged.
REQ-022 SHALL drive in_ready = (count < 2) from registered state only, no combinational path from out_ready.
REQ-023 SHALL drive out_valid = (count != 0); out_field/out_fit SHALL hold stable while out_valid && !out_ready.
REQ-024 SHALL deliver results in acceptance order; read/write pointers wrap modulo 2.
REQ-025 SHALL increment err_count by 1 on each accepted request with fit = 0, holding at 16'hFFFF when saturated.
REQ-026 SHALL ignore in_imm/in_src when not accepted; no state change.
REQ-027 SHALL, with count = 2 and out_ready = 1, still deassert in_ready that cycle (accept resumes next cycle).

Reset
REQ-028 SHALL, on clk edge with rst = 1, set count = 0, pointers = 0, err_count = 0, out_valid = 0, in_ready = 1 next cycle.
REQ-029 SHALL discard buffered entries on reset mid-operation; a request presented in the reset cycle SHALL NOT be accepted.
REQ-030 SHALL drive out_field = 0, out_fit = 0 while out_valid = 0.

Verification
REQ-031 SHALL verify: src 00, imm 0x7F -> field 0x0007F, fit 1; imm 0x80 -> field 0, fit 0, err_count 1.
REQ-032 SHALL verify: src 10, imm 0xFFFFFFF8 -> field 0x1FFFFE, fit 1; imm 0x00400000 -> fit 0; imm 0x6 -> fit 0.
REQ-033 SHALL verify: src 01, imm 0x7FF -> field 0x007FF fit 1; src 11 any imm -> fit 0, field 0.
REQ-034 SHALL verify: out_ready = 0, three back-to-back requests -> two accepted, in_ready 0 from cycle 2; releasing out_ready drains in order.
REQ-035 SHALL verify: full buffer, rst pulse -> out_valid 0, err_count 0, in_ready 1 next cycle, old entries never appear.
REQ-036 SHALL verify: 65536 failing requests -> err_count = 0xFFFF, remaining at 0xFFFF after further failures.

Source files
------------

// File: rtl/imm_encoder.sv
// Packs a 32-bit immediate into a 21-bit instruction field and reports whether it fits.
// Results pass through a two-entry output buffer; failed packs feed a saturating error counter.
module imm_encoder #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_imm,
  input  logic [1:0]  in_src,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [20:0] out_field,
  output logic        out_fit,
  output logic [15:0] err_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  // Returns {fit, field}; field is zeroed whenever the value does not fit.
  function automatic logic [21:0] encode(input logic [31:0] imm, input logic [1:0] src);
    logic        fit;
    logic [20:0] field;
    fit   = 1'b0;
    field = '0;
    case (src)
      2'b00: begin
        fit   = (imm[31:7] == '0);
        field = {14'b0, imm[6:0]};
      end
      2'b01: begin
        fit   = (imm[31:11] == '0);
        field = {10'b0, imm[10:0]};
      end
      2'b10: begin
        // bit 22 is included so the upper sign extension reproduces imm exactly
        fit   = (imm[1:0] == 2'b00) && ((imm[31:22] == '0) || (imm[31:22] == '1));
        field = imm[22:2];
      end
      default: begin
        fit   = 1'b0;
        field = '0;
      end
    endcase
    if (!fit) field = '0;
    return {fit, field};
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] val);
    return (val == 16'hFFFF) ? val : val + 16'd1;
  endfunction

  // Stage p0: combinational encode of the presented request
  logic [21:0] enc_p0;
  logic        push, pop;

  assign enc_p0 = encode(in_imm, in_src);

  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;

  assign in_ready  = (count < FULL);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready && !rst;
  assign pop       = out_valid && out_ready;

  // Stage p1: buffered results, data registers carry no reset
  logic [20:0] field_p1 [DEPTH];
  logic        fit_p1   [DEPTH];

  always_ff @(posedge clk) begin
    if (push) begin
      field_p1[wr_ptr] <= enc_p0[20:0];
      fit_p1[wr_ptr]   <= enc_p0[21];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      err_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
        if (!enc_p0[21]) err_count <= sat_inc(err_count);
      end
      if (pop) rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign out_field = out_valid ? field_p1[rd_ptr] : '0;
  assign out_fit   = out_valid ? fit_p1[rd_ptr]   : 1'b0;

endmodule

// File: tb/tb_imm_encoder.sv
// Directed bench for imm_encoder: packing rules, buffer flow control, reset and error saturation.
module tb_imm_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_imm;
  logic [1:0]  in_src;
  logic        out_valid;
  logic        out_ready;
  logic [20:0] out_field;
  logic        out_fit;
  logic [15:0] err_count;

  int n_vec = 0;
  int n_err = 0;

  imm_encoder #(.DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm), .in_src(in_src),
    .out_valid(out_valid), .out_ready(out_ready), .out_field(out_field),
    .out_fit(out_fit), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One request through an empty buffer, then inspect the head and pop it.
  task automatic one(input string tag, input logic [1:0] src, input logic [31:0] imm,
                     input logic [20:0] exp_field, input logic exp_fit, input logic [15:0] exp_err);
    check({tag, "_rdy"}, {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1; in_src = src; in_imm = imm;
    step();
    in_valid = 1'b0; in_imm = 32'hDEAD_BEEF; in_src = 2'b00;
    check({tag, "_vld"},   {31'b0, out_valid}, 32'd1);
    check({tag, "_field"}, {11'b0, out_field}, {11'b0, exp_field});
    check({tag, "_fit"},   {31'b0, out_fit},   {31'b0, exp_fit});
    check({tag, "_err"},   {16'b0, err_count}, {16'b0, exp_err});
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, "_empty"}, {31'b0, out_valid}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_imm = '0; in_src = '0; out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    check("rst_vld",   {31'b0, out_valid}, 32'd0);
    check("rst_rdy",   {31'b0, in_ready},  32'd1);
    check("rst_err",   {16'b0, err_count}, 32'd0);
    check("rst_field", {11'b0, out_field}, 32'd0);
    check("rst_fit",   {31'b0, out_fit},   32'd0);

    // Idle inputs must not change state
    in_imm = 32'h1234; in_src = 2'b11;
    step();
    check("idle_vld", {31'b0, out_valid}, 32'd0);
    check("idle_err", {16'b0, err_count}, 32'd0);

    one("s00_7f",    2'b00, 32'h0000_007F, 21'h0007F, 1'b1, 16'd0);
    one("s00_80",    2'b00, 32'h0000_0080, 21'h00000, 1'b0, 16'd1);
    one("s10_neg8",  2'b10, 32'hFFFF_FFF8, 21'h1FFFFE, 1'b1, 16'd1);
    one("s10_b22",   2'b10, 32'h0040_0000, 21'h00000, 1'b0, 16'd2);
    one("s10_unal",  2'b10, 32'h0000_0006, 21'h00000, 1'b0, 16'd3);
    one("s01_7ff",   2'b01, 32'h0000_07FF, 21'h007FF, 1'b1, 16'd3);
    one("s01_800",   2'b01, 32'h0000_0800, 21'h00000, 1'b0, 16'd4);
    one("s11_5",     2'b11, 32'h0000_0005, 21'h00000, 1'b0, 16'd5);
    one("s10_maxp",  2'b10, 32'h003F_FFFC, 21'h0FFFFF, 1'b1, 16'd5);
    one("s10_minn",  2'b10, 32'hFFC0_0000, 21'h100000, 1'b1, 16'd5);

    // Backpressure: three back-to-back requests, consumer stalled
    in_valid = 1'b1; in_src = 2'b00; in_imm = 32'h11;
    step();
    check("bp_rdy1", {31'b0, in_ready}, 32'd1);
    in_src = 2'b01; in_imm = 32'h222;
    step();
    check("bp_rdy2", {31'b0, in_ready}, 32'd0);
    in_src = 2'b00; in_imm = 32'h33;
    step();
    check("bp_rdy3", {31'b0, in_ready}, 32'd0);
    in_valid = 1'b0;
    check("bp_head_hold", {11'b0, out_field}, 32'h11);
    out_ready = 1'b1;
    check("bp_full_pop_rdy", {31'b0, in_ready}, 32'd0);
    check("bp_a", {11'b0, out_field}, 32'h11);
    step();
    check("bp_b", {11'b0, out_field}, 32'h222);
    check("bp_b_rdy", {31'b0, in_ready}, 32'd1);
    step();
    check("bp_drained", {31'b0, out_valid}, 32'd0);
    out_ready = 1'b0;
    check("bp_err", {16'b0, err_count}, 32'd5);

    // Reset with a full buffer and a request presented during reset
    in_valid = 1'b1; in_src = 2'b11; in_imm = 32'h1;
    step();
    in_src = 2'b00; in_imm = 32'h44;
    step();
    check("rf_full", {31'b0, in_ready}, 32'd0);
    check("rf_err",  {16'b0, err_count}, 32'd6);
    rst = 1'b1; in_src = 2'b00; in_imm = 32'h55;
    step();
    rst = 1'b0; in_valid = 1'b0;
    check("rf_vld",   {31'b0, out_valid}, 32'd0);
    check("rf_err0",  {16'b0, err_count}, 32'd0);
    check("rf_rdy",   {31'b0, in_ready},  32'd1);
    check("rf_field", {11'b0, out_field}, 32'd0);
    out_ready = 1'b1;
    step();
    step();
    check("rf_stale", {31'b0, out_valid}, 32'd0);

    // Saturation of the error counter
    in_valid = 1'b1; in_src = 2'b11; in_imm = 32'hABCD;
    repeat (65534) step();
    check("sat_fffe", {16'b0, err_count}, 32'h0000_FFFE);
    step();
    check("sat_ffff", {16'b0, err_count}, 32'h0000_FFFF);
    step();
    check("sat_65536", {16'b0, err_count}, 32'h0000_FFFF);
    repeat (10) step();
    check("sat_hold", {16'b0, err_count}, 32'h0000_FFFF);
    in_valid = 1'b0;
    step();
    step();
    check("sat_drain", {31'b0, out_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
